ycr_mport_router: RTL

YCR_MPORT_ROUTER -- requirements
Module: ycr_mport_router

---
 rtl/ycr_mport_router_if.sv | 45 ++++
 rtl/ycr_mport_router.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/ycr_mport_router_if.sv
// Bus bundle between NP requesting masters, the router and its single downstream slave.
// The slave modport is the router's view; the master modport is the surrounding environment.
interface ycr_mport_router_if #(
  parameter int unsigned NP   = 4,
  parameter int unsigned TIDW = 3,
  parameter int unsigned AW   = 32,
  parameter int unsigned DW   = 32,
  parameter int unsigned BW   = 3
);
  logic [NP-1:0]      m_req;
  logic [NP-1:0]      m_cmd;
  logic [2*NP-1:0]    m_width;
  logic [TIDW*NP-1:0] m_tid;
  logic [AW*NP-1:0]   m_addr;
  logic [BW*NP-1:0]   m_bl;
  logic [DW*NP-1:0]   m_wdata;
  logic [NP-1:0]      m_req_ack;
  logic [NP-1:0]      m_lack;
  logic [DW*NP-1:0]   m_rdata;
  logic [2*NP-1:0]    m_resp;

  logic               s_req;
  logic               s_cmd;
  logic [1:0]         s_width;
  logic [AW-1:0]      s_addr;
  logic [BW-1:0]      s_bl;
  logic [DW-1:0]      s_wdata;
  logic               s_req_ack;
  logic [DW-1:0]      s_rdata;
  logic [1:0]         s_resp;

  modport slave (
    input  m_req, m_cmd, m_width, m_tid, m_addr, m_bl, m_wdata,
    output m_req_ack, m_lack, m_rdata, m_resp,
    output s_req, s_cmd, s_width, s_addr, s_bl, s_wdata,
    input  s_req_ack, s_rdata, s_resp
  );

  modport master (
    output m_req, m_cmd, m_width, m_tid, m_addr, m_bl, m_wdata,
    input  m_req_ack, m_lack, m_rdata, m_resp,
    input  s_req, s_cmd, s_width, s_addr, s_bl, s_wdata,
    output s_req_ack, s_rdata, s_resp
  );
endinterface

// File: rtl/ycr_mport_router.sv
// Arbitrates NP masters onto one target port: IDLE picks a winner, CMD carries the request,
// RESP forwards response beats until a lock, an error or a response timeout ends the grant.
module ycr_mport_router #(
  parameter int unsigned NP       = 4,
  parameter int unsigned TIDW     = 3,
  parameter int unsigned AW       = 32,
  parameter int unsigned DW       = 32,
  parameter int unsigned BW       = 3,
  parameter int unsigned ARB_MODE = 0,
  parameter int unsigned LACK_EN  = 0,
  parameter int unsigned TMO      = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [TIDW-1:0]       target_id,
  ycr_mport_router_if.slave     bus,
  output logic [$clog2(NP)-1:0] gnt_id,
  output logic                  busy
);
  localparam int unsigned GW = $clog2(NP);
  localparam int unsigned CW = (TMO > 0) ? $clog2(TMO + 1) : 1;
  localparam logic [CW-1:0] CntMax = (TMO > 0) ? CW'(TMO) : {CW{1'b1}};

  localparam logic [1:0] RespNotRdy = 2'b00;
  localparam logic [1:0] RespOk     = 2'b01;
  localparam logic [1:0] RespEr     = 2'b10;
  localparam logic [1:0] RespLok    = 2'b11;

  typedef enum logic [1:0] {StIdle, StCmd, StResp} state_e;

  state_e        state_q;
  logic [GW-1:0] gnt_q, last_q;
  logic [CW-1:0] cnt_q;

  logic [NP-1:0] elig;
  logic [GW-1:0] win, idx;
  logic          any_elig;
  logic          g_req;
  logic          tmo_hit;
  logic [1:0]    resp_fwd;
  logic [31:0]   gi;

  assign gi       = 32'(gnt_q);
  assign g_req    = bus.m_req[gnt_q];
  assign any_elig = |elig;
  assign gnt_id   = gnt_q;
  assign busy     = (state_q != StIdle);

  always_comb begin
    elig = '0;
    for (int i = 0; i < NP; i++) begin
      elig[i] = bus.m_req[i] && (bus.m_tid[i*TIDW +: TIDW] == target_id);
    end
  end

  // Later loop iterations override earlier ones, so scan from lowest to highest priority.
  always_comb begin
    win = '0;
    idx = '0;
    if (ARB_MODE != 0) begin
      for (int i = NP - 1; i >= 0; i--) begin
        if (elig[i]) win = GW'(i);
      end
    end else begin
      for (int k = NP; k >= 1; k--) begin
        idx = GW'((32'(last_q) + 32'(k)) % NP);
        if (elig[idx]) win = idx;
      end
    end
  end

  // The count reaches TMO on this NOTRDY beat.
  assign tmo_hit = (TMO != 0) && (state_q == StResp) && (bus.s_resp == RespNotRdy) &&
                   ((32'(cnt_q) + 32'd1) == TMO);

  always_comb begin
    resp_fwd = bus.s_resp;
    if (bus.s_resp == RespLok && LACK_EN == 0) begin
      resp_fwd = RespOk;
    end else if (tmo_hit) begin
      resp_fwd = RespEr;
    end
  end

  always_comb begin
    bus.s_req     = 1'b0;
    bus.s_cmd     = 1'b0;
    bus.s_width   = '0;
    bus.s_addr    = '0;
    bus.s_bl      = '0;
    bus.s_wdata   = '0;
    bus.m_req_ack = '0;
    bus.m_lack    = '0;
    bus.m_rdata   = '0;
    bus.m_resp    = '0;
    unique case (state_q)
      StCmd: begin
        bus.s_req            = g_req;
        bus.s_cmd            = bus.m_cmd[gnt_q];
        bus.s_width          = bus.m_width[gi*2 +: 2];
        bus.s_addr           = bus.m_addr[gi*AW +: AW];
        bus.s_bl             = bus.m_bl[gi*BW +: BW];
        bus.s_wdata          = bus.m_wdata[gi*DW +: DW];
        bus.m_req_ack[gnt_q] = bus.s_req_ack & g_req;
      end
      StResp: begin
        bus.s_wdata              = bus.m_wdata[gi*DW +: DW];
        bus.m_rdata[gi*DW +: DW] = bus.s_rdata;
        bus.m_resp[gi*2 +: 2]    = resp_fwd;
        bus.m_lack[gnt_q]        = (bus.s_resp == RespLok);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      last_q  <= GW'(NP - 1);
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (any_elig) begin
            gnt_q   <= win;
            state_q <= StCmd;
          end
        end
        StCmd: begin
          if (!g_req) begin
            state_q <= StIdle;
          end else if (bus.s_req_ack) begin
            state_q <= StResp;
            cnt_q   <= '0;
          end
        end
        StResp: begin
          if (bus.s_resp != RespNotRdy) begin
            cnt_q <= '0;
          end else if (cnt_q != CntMax) begin
            cnt_q <= cnt_q + CW'(1);
          end
          if (bus.s_resp == RespLok || bus.s_resp == RespEr || tmo_hit) begin
            last_q  <= gnt_q;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end
endmodule
